// File: rtl/contador_estados_param_pkg.sv
// contador_pkg: shared coding type and binary/Gray conversion helpers for the state counter.
// Helpers work on a fixed 32-bit word; callers zero-extend and truncate to their own width.
package contador_pkg;

    typedef enum logic {
        BINARIO = 1'b0,
        GRAY    = 1'b1
    } modo_t;

    localparam int WMAX = 32;

    function automatic logic [WMAX-1:0] bin2gray(input logic [WMAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
    function automatic logic [WMAX-1:0] gray2bin(input logic [WMAX-1:0] g);
        logic [WMAX-1:0] b;
        b[WMAX-1] = g[WMAX-1];
        for (int i = WMAX - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/contador_estados_param_siguiente.sv
// siguiente_cuenta: combinational next-count and wrap flag for the up/down modulus counter.
module siguiente_cuenta #(
    parameter int N   = 3,
    parameter int MAX = 2**N - 1
) (
    input  logic [N-1:0] cnt,
    input  logic         x,
    input  logic         en,
    input  logic         saturar,
    input  logic         carga,
    input  logic [N-1:0] carga_val,
    output logic [N-1:0] sig,
    output logic         wrap
);

    logic tope;
    logic piso;
    logic [N-1:0] arriba;
    logic [N-1:0] abajo;

    always_comb begin
        tope   = cnt == N'(MAX);
        piso   = cnt == '0;
        arriba = tope ? (saturar ? cnt : '0) : cnt + N'(1);
        abajo  = piso ? (saturar ? cnt : N'(MAX)) : cnt - N'(1);
        sig    = carga ? carga_val : !en ? cnt : x ? arriba : abajo;
        wrap   = !carga && en && !saturar && (x ? tope : piso);
    end

endmodule

// File: rtl/contador_estados_param.sv
// contador_estados_param: N-bit up/down modulus counter with binary/Gray coding, saturate/wrap
// and synchronous load; holds the state register and the output coding.
module contador_estados_param
    import contador_pkg::*;
#(
    parameter int N   = 3,
    parameter int MAX = 2**N - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         x,
    input  logic         modo,
    input  logic         saturar,
    input  logic         carga,
    input  logic [N-1:0] dato,
    output logic [N-1:0] estado,
    output logic [N-1:0] cuenta,
    output logic         fin,
    output logic         en_max,
    output logic         en_min
);

    logic [N-1:0] cnt;
    logic [N-1:0] carga_bin;
    logic [N-1:0] carga_val;
    logic [N-1:0] sig;
    logic         wrap;
    logic         es_gray;

    assign es_gray = modo_t'(modo) == GRAY;

    // Loads arrive in the current coding; out-of-range values clamp to the last count.
    always_comb begin
        carga_bin = es_gray ? N'(gray2bin(WMAX'(dato))) : dato;
        carga_val = carga_bin > N'(MAX) ? N'(MAX) : carga_bin;
    end

    siguiente_cuenta #(.N(N), .MAX(MAX)) u_sig (
        .cnt       (cnt),
        .x         (x),
        .en        (en),
        .saturar   (saturar),
        .carga     (carga),
        .carga_val (carga_val),
        .sig       (sig),
        .wrap      (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            fin <= 1'b0;
        end else begin
            cnt <= sig;
            fin <= wrap;
        end
    end

    assign cuenta = cnt;
    assign estado = es_gray ? N'(bin2gray(WMAX'(cnt))) : cnt;
    assign en_max = cnt == N'(MAX);
    assign en_min = cnt == '0;

endmodule

// File: tb/tb_contador_estados_param.sv
// tb_contador_estados_param: table-driven scoreboard bench for two counter instances
// (MAX=7 and MAX=5, both N=3) plus hand checks of the immediate modo -> estado path.
module tb_contador_estados_param;

    typedef struct packed {
        logic reset, en, x, modo, saturar, carga;
        logic [2:0] dato;
    } in_t;

    typedef struct packed {
        logic [2:0] estado, cuenta;
        logic fin, en_max, en_min;
    } out_t;

    typedef struct {
        bit   sel;
        in_t  i;
        out_t o;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t in7 = '0;
    in_t in5 = '0;
    logic [2:0] e7, c7, e5, c5;
    logic f7, mx7, mn7, f5, mx5, mn5;

    contador_estados_param #(.N(3), .MAX(7)) dut7 (
        .clk(clk), .reset(in7.reset), .en(in7.en), .x(in7.x), .modo(in7.modo),
        .saturar(in7.saturar), .carga(in7.carga), .dato(in7.dato),
        .estado(e7), .cuenta(c7), .fin(f7), .en_max(mx7), .en_min(mn7)
    );

    contador_estados_param #(.N(3), .MAX(5)) dut5 (
        .clk(clk), .reset(in5.reset), .en(in5.en), .x(in5.x), .modo(in5.modo),
        .saturar(in5.saturar), .carga(in5.carga), .dato(in5.dato),
        .estado(e5), .cuenta(c5), .fin(f5), .en_max(mx5), .en_min(mn5)
    );

    int   tests = 0;
    int   fails = 0;
    vec_t tbl[$];
    out_t sb[$];
    int   hand_at = -1;

    // ctl = {reset, en, x, modo, saturar, carga}; flags = {fin, en_max, en_min}
    function automatic vec_t mk(bit s, logic [5:0] ctl, logic [2:0] d,
                                logic [2:0] est, logic [2:0] cue, logic [2:0] flags);
        vec_t v;
        v.sel = s;
        v.i   = {ctl, d};
        v.o   = {est, cue, flags};
        return v;
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t t);
        out_t exp, act;
        @(negedge clk);
        in7 = '0;
        in5 = '0;
        if (t.sel) in5 = t.i;
        else       in7 = t.i;
        sb.push_back(t.o);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        act = t.sel ? {e5, c5, f5, mx5, mn5} : {e7, c7, f7, mx7, mn7};
        chk($sformatf("vec%0d dut%0d {estado,cuenta,fin,en_max,en_min}", k, t.sel ? 5 : 7), act, exp);
    endtask

    initial begin
        // Gray count up through the full modulus of the MAX=7 instance
        tbl.push_back(mk(0, 6'b100000, 3'd0, 3'b000, 3'd0, 3'b001));
        tbl.push_back(mk(0, 6'b011100, 3'd0, 3'b001, 3'd1, 3'b000));
        tbl.push_back(mk(0, 6'b011100, 3'd0, 3'b011, 3'd2, 3'b000));
        tbl.push_back(mk(0, 6'b011100, 3'd0, 3'b010, 3'd3, 3'b000));
        tbl.push_back(mk(0, 6'b011100, 3'd0, 3'b110, 3'd4, 3'b000));
        tbl.push_back(mk(0, 6'b011100, 3'd0, 3'b111, 3'd5, 3'b000));
        tbl.push_back(mk(0, 6'b011100, 3'd0, 3'b101, 3'd6, 3'b000));
        tbl.push_back(mk(0, 6'b011100, 3'd0, 3'b100, 3'd7, 3'b010));
        tbl.push_back(mk(0, 6'b011100, 3'd0, 3'b000, 3'd0, 3'b101));
        // MAX=5 binary count down with wrap
        tbl.push_back(mk(1, 6'b100000, 3'd0, 3'd0, 3'd0, 3'b001));
        tbl.push_back(mk(1, 6'b010000, 3'd0, 3'd5, 3'd5, 3'b110));
        tbl.push_back(mk(1, 6'b010000, 3'd0, 3'd4, 3'd4, 3'b000));
        tbl.push_back(mk(1, 6'b010000, 3'd0, 3'd3, 3'd3, 3'b000));
        tbl.push_back(mk(1, 6'b010000, 3'd0, 3'd2, 3'd2, 3'b000));
        tbl.push_back(mk(1, 6'b010000, 3'd0, 3'd1, 3'd1, 3'b000));
        tbl.push_back(mk(1, 6'b010000, 3'd0, 3'd0, 3'd0, 3'b001));
        tbl.push_back(mk(1, 6'b010000, 3'd0, 3'd5, 3'd5, 3'b110));
        // Saturating up count on MAX=7, hold at top, then step down
        tbl.push_back(mk(0, 6'b100000, 3'd0, 3'd0, 3'd0, 3'b001));
        for (int k = 1; k <= 6; k++)
            tbl.push_back(mk(0, 6'b011010, 3'd0, 3'(k), 3'(k), 3'b000));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 6'b011010, 3'd0, 3'd7, 3'd7, 3'b010));
        tbl.push_back(mk(0, 6'b010010, 3'd0, 3'd6, 3'd6, 3'b000));
        // Gray-coded load, then immediate modo check by hand
        tbl.push_back(mk(0, 6'b000101, 3'b110, 3'b110, 3'd4, 3'b000));
        hand_at = tbl.size() - 1;
        tbl.push_back(mk(1, 6'b000101, 3'b100, 3'b111, 3'd5, 3'b010));
        tbl.push_back(mk(1, 6'b000001, 3'd6, 3'd5, 3'd5, 3'b010));
        // Load priority over en, reset priority over load, fin cleared by load
        tbl.push_back(mk(0, 6'b011001, 3'd2, 3'd2, 3'd2, 3'b000));
        tbl.push_back(mk(0, 6'b100001, 3'd5, 3'd0, 3'd0, 3'b001));
        tbl.push_back(mk(0, 6'b000001, 3'd7, 3'd7, 3'd7, 3'b010));
        tbl.push_back(mk(0, 6'b011000, 3'd0, 3'd0, 3'd0, 3'b101));
        tbl.push_back(mk(0, 6'b000001, 3'd3, 3'd3, 3'd3, 3'b000));
        tbl.push_back(mk(0, 6'b000000, 3'd0, 3'd3, 3'd3, 3'b000));
        // MAX=5 wrap up and saturate at zero
        tbl.push_back(mk(1, 6'b000001, 3'd5, 3'd5, 3'd5, 3'b010));
        tbl.push_back(mk(1, 6'b011000, 3'd0, 3'd0, 3'd0, 3'b101));
        tbl.push_back(mk(1, 6'b010010, 3'd0, 3'd0, 3'd0, 3'b001));
        // Reset mid-count while enabled, then resume
        tbl.push_back(mk(0, 6'b100000, 3'd0, 3'd0, 3'd0, 3'b001));
        for (int k = 1; k <= 6; k++)
            tbl.push_back(mk(0, 6'b011000, 3'd0, 3'(k), 3'(k), 3'b000));
        tbl.push_back(mk(0, 6'b111000, 3'd0, 3'd0, 3'd0, 3'b001));
        tbl.push_back(mk(0, 6'b011000, 3'd0, 3'd1, 3'd1, 3'b000));

        for (int k = 0; k < tbl.size(); k++) begin
            run_vec(k, tbl[k]);
            if (k == hand_at) begin
                @(negedge clk);
                in7 = '0;
                #1;
                chk("modo0 estado", {6'd0, e7}, {6'd0, 3'b100});
                in7.modo = 1'b1;
                #1;
                chk("modo1 estado", {6'd0, e7}, {6'd0, 3'b110});
                chk("modo cuenta unchanged", {6'd0, c7}, {6'd0, 3'd4});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/contador_estados_param.md
# contador_estados_param

Parametrised up/down state counter that generalises the 3-bit hand-reduced next-state FSM into an N-bit register with selectable binary or Gray output coding, programmable modulus, wrap or saturate mode, and synchronous load. It drives the display/sequencing stage of the lab designs: the state register plus next-state logic live here, and downstream decoders consume `estado`, `cuenta` and the bound flags.

## Interface
- `N`, default 3: counter width in bits; must be ≥ 2.
- `MAX`, default 2**N-1: last count value; modulus is MAX+1; must satisfy 1 ≤ MAX ≤ 2**N-1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `en`  in  1  count enable.
- `x`  in  1  direction: 1 counts up, 0 counts down.
- `modo`  in  1  output/load coding: 0 binary, 1 Gray.
- `saturar`  in  1  bound behaviour: 0 wrap, 1 hold at bound.
- `carga`  in  1  synchronous load strobe.
- `dato`  in  N  load value, coded per `modo`.
- `estado`  out  N  current count, coded per `modo`.
- `cuenta`  out  N  current count, always binary.
- `fin`  out  1  one-cycle pulse, registered, after a wrap.
- `en_max`  out  1  level: binary count == MAX.
- `en_min`  out  1  level: binary count == 0.

## Operation
- Internal state: binary register `cnt[N-1:0]` and flop `fin`. `cuenta` = `cnt`; `estado` = `cnt` when `modo`=0, else `cnt ^ (cnt >> 1)`.
- `en_max` and `en_min` decode `cnt` only. No combinational path from inputs to any output except `modo` → `estado`.
- Priority per edge: `reset` > `carga` > `en` > hold.
- `reset`: `cnt`←0, `fin`←0. Outputs after reset: `estado`=0, `cuenta`=0, `fin`=0, `en_max`=(MAX==0 ? 1 : 0), which is always 0 given MAX ≥ 1, and `en_min`=1.
- `carga`: `dato` is converted to binary if `modo`=1 (Gray→binary prefix XOR). Results above MAX are clamped to MAX. `fin`←0. `en` is ignored that cycle.
- `en`, `x`=1: if `cnt`<MAX then `cnt`+1. At MAX, `saturar`=0 gives `cnt`←0 and `fin`←1; `saturar`=1 holds and `fin`←0.
- `en`, `x`=0: if `cnt`>0 then `cnt`-1. At 0, `saturar`=0 gives `cnt`←MAX and `fin`←1; `saturar`=1 holds and `fin`←0.
- Any cycle without a wrap: `fin`←0. `fin` is never high on two consecutive cycles unless wraps occur on consecutive enabled edges.
- Changing `modo` does not alter `cnt`; only the coding of `estado` and the interpretation of `dato` change, both immediately.
- Gray single-bit-change holds on every step when MAX = 2**N-1. For other MAX values the wrap transition may change several bits; this is accepted.

## Timing
- Latency: one clock from `en`/`carga`/`reset` sampled high to the new `cnt`/`estado`/`cuenta`/`en_*`. `fin` rises in the same cycle as the wrapped value.
- Throughput: one step per clock while `en`=1.
- `reset` asserted mid-count wins over a simultaneous `carga`/`en`. `carga` and `en` together means the load wins.
- `x` and `saturar` are sampled only on enabled edges and may change every cycle.

## Structure
- Package `contador_pkg`:
  - typedef `modo_t` (BINARIO=0, GRAY=1);
  - functions `bin2gray(logic [N-1:0])` and `gray2bin(logic [N-1:0])`, parametrised via a width parameter or a fixed-maximum width with truncation.
- Sub-module `siguiente_cuenta`: purely combinational next-count and wrap-flag logic (inputs `cnt`, `x`, `en`, `saturar`, `carga`, binary load value; outputs next `cnt`, `wrap`).
- The top holds the registers, load conversion/clamp and output coding.

## Test plan
- N=3, MAX=7, reset, then `en`=1, `x`=1, `modo`=1 for 8 clocks → `estado` 001,011,010,110,111,101,100,000. `fin`=1 only on the cycle showing 000. Exactly one bit changes per step.
- N=3, MAX=5, `modo`=0, `x`=0 from reset, `saturar`=0 → `cuenta` 5,4,3,2,1,0,5. `fin` pulses on the first 5. `en_min`=1 at 0.
- N=3, MAX=7, `saturar`=1, count up to 7 then 3 more enabled clocks → holds 7, `en_max`=1, `fin` stays 0. Then `x`=0 → 6.
- `modo`=1, `carga`=1, `dato`=3'b110 → `cuenta`=4, `estado`=110. With MAX=5, `dato`=3'b100 (binary 7) → clamped to `cuenta`=5.
- `carga` and `en` high in the same cycle, `dato`=2 → `cuenta`=2, no increment. `reset` together with `carga` → `cuenta`=0, `fin`=0.
- Count to 6 up, assert `reset` for 1 cycle while `en`=1 → next `cuenta`=0, `en_min`=1. Counting resumes at 1 the following cycle.
